// File: rtl/mult_div_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_div_seq_if : request/result bundle for the mult/div engine   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output start, op, is_signed, a, b,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  start, op, is_signed, a, b,
    output busy, done, hi, lo, div0
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mult_div_seq : iterative shift-add multiply / restoring divide    |
// | Optional macro MD_EARLY_ZERO_EN: short-cut for zero operands      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_seq_if.slave  md
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic               op_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_pend_q;
  logic               zero_pend_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               a_neg_d;
  logic               b_neg_d;
  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic               early_zero_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [WIDTH:0]     div_cand_d;
  logic [WIDTH:0]     div_diff_d;
  logic [WIDTH-1:0]   div_rem_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;

  always_comb begin
    a_neg_d = md.is_signed & md.a[WIDTH-1];
    b_neg_d = md.is_signed & md.b[WIDTH-1];
    a_mag_d = a_neg_d ? -md.a : md.a;
    b_mag_d = b_neg_d ? -md.b : md.b;

`ifdef MD_EARLY_ZERO_EN
    early_zero_d = (!md.op && ((md.a == '0) || (md.b == '0))) ||
                   ( md.op && (md.a == '0) && (md.b != '0));
`else
    early_zero_d = 1'b0;
`endif

    // Multiply: add multiplicand into the top half, then shift the pair right.
    mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

    // Divide: top half is the partial remainder, dividend bits enter from opa_q.
    div_cand_d = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    div_diff_d = div_cand_d - {1'b0, opb_q};
    div_rem_d  = div_diff_d[WIDTH] ? div_cand_d[WIDTH-1:0] : div_diff_d[WIDTH-1:0];

    prod_d = neg_res_q ? -acc_q : acc_q;
    quo_d  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_pend_q <= 1'b0;
      zero_pend_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div0_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md.start) begin
            op_q        <= md.op;
            neg_res_q   <= a_neg_d ^ b_neg_d;
            neg_rem_q   <= a_neg_d;
            opa_q       <= a_mag_d;
            opb_q       <= b_mag_d;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            div0_q      <= 1'b0;
            div0_pend_q <= md.op && (md.b == '0);
            zero_pend_q <= early_zero_d;
            // Degenerate cases finish on the very next edge without iterating.
            if ((md.op && (md.b == '0)) || early_zero_d) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (op_q) begin
            acc_q <= {div_rem_d, acc_q[WIDTH-2:0], ~div_diff_d[WIDTH]};
            opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_q <= {mul_sum_d, acc_q[WIDTH-1:1]};
            opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          if (div0_pend_q) begin
            div0_q <= 1'b1;
          end else if (zero_pend_q) begin
            hi_q <= '0;
            lo_q <= '0;
          end else if (op_q) begin
            hi_q <= rem_d;
            lo_q <= quo_d;
          end else begin
            hi_q <= prod_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_d[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.div0 = div0_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mult_div_seq : directed vector bench for mult_div_seq          |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_mult_div_seq;
  localparam int W   = 32;
  localparam int LAT = W + 2;
  localparam int NV  = 16;

  typedef struct {
    logic         op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           chk_lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mult_div_seq_if #(.WIDTH(W)) mif ();

  mult_div_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .md    (mif)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input logic op, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke,
                        output int lat, output int busy_cyc);
    mif.op        = op;
    mif.is_signed = sgn;
    mif.a         = a;
    mif.b         = b;
    mif.start     = 1'b1;
    @(posedge clock);
    #1;
    mif.start     = 1'b0;
    mif.op        = ~op;
    mif.is_signed = ~sgn;
    mif.a         = ~a;
    mif.b         = ~b;
    lat      = 1;
    busy_cyc = 0;
    forever begin
      @(negedge clock);
      if (mif.busy) busy_cyc++;
      if (mif.done) break;
      if (lat >= 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: got no done after %0d edges, expected done by %0d", lat, LAT);
        lat = -1;
        break;
      end
      if (lat == poke) begin
        mif.start     = 1'b1;
        mif.op        = 1'b1;
        mif.is_signed = 1'b0;
        mif.a         = 32'd5;
        mif.b         = 32'd0;
      end else begin
        mif.start = 1'b0;
      end
      @(posedge clock);
      lat++;
    end
    mif.start = 1'b0;
  endtask

  vec_t vecs [NV];
  int   lat;
  int   bc;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};

    mif.start     = 1'b0;
    mif.op        = 1'b0;
    mif.is_signed = 1'b0;
    mif.a         = '0;
    mif.b         = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", {63'd0, mif.busy}, 64'd0);
    check("reset_done", {63'd0, mif.done}, 64'd0);
    check("reset_div0", {63'd0, mif.div0}, 64'd0);
    check("reset_hilo", {mif.hi, mif.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Each vector after the first starts in the cycle where the previous done is high.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, 0, lat, bc);
      check($sformatf("vec%0d_hi", i), {32'd0, mif.hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_lo", i), {32'd0, mif.lo}, {32'd0, vecs[i].lo});
      check($sformatf("vec%0d_div0", i), {63'd0, mif.div0}, 64'd0);
      if (vecs[i].chk_lat) begin
        check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
        check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(W + 1));
      end
    end

    check("b2b_done_high", {63'd0, mif.done}, 64'd1);
    run_op(1'b0, 1'b0, 32'd6, 32'd7, 0, lat, bc);
    check("b2b_latency", 64'(lat), 64'(LAT));
    check("b2b_result", {mif.hi, mif.lo}, 64'd42);
    @(negedge clock);
    check("done_one_cycle", {63'd0, mif.done}, 64'd0);
    check("busy_idle", {63'd0, mif.busy}, 64'd0);
    repeat (5) @(negedge clock);
    check("result_hold", {mif.hi, mif.lo}, 64'd42);

    run_op(1'b1, 1'b0, 32'h0000_0451, 32'h0000_0020, 0, lat, bc);
    check("pre_div0_result", {mif.hi, mif.lo}, {32'h11, 32'h22});
    @(negedge clock);
    run_op(1'b1, 1'b1, 32'h0000_1234, 32'h0000_0000, 0, lat, bc);
    check("div0_latency", 64'(lat), 64'd2);
    check("div0_flag", {63'd0, mif.div0}, 64'd1);
    check("div0_busy_cycles", 64'(bc), 64'd1);
    check("div0_hilo_kept", {mif.hi, mif.lo}, {32'h11, 32'h22});
    repeat (4) @(negedge clock);
    check("div0_flag_hold", {63'd0, mif.div0}, 64'd1);
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 0, lat, bc);
    check("div0_cleared", {63'd0, mif.div0}, 64'd0);
    check("after_div0_result", {mif.hi, mif.lo}, 64'd15);
    @(negedge clock);

    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, bc);
    check("busy_start_latency", 64'(lat), 64'(LAT));
    check("busy_start_result", {mif.hi, mif.lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    check("busy_start_div0", {63'd0, mif.div0}, 64'd0);
    repeat (3) @(negedge clock);
    check("busy_start_no_queue", {63'd0, mif.busy}, 64'd0);

    mif.op        = 1'b0;
    mif.is_signed = 1'b1;
    mif.a         = 32'hFFFF_FFFD;
    mif.b         = 32'h0000_0007;
    mif.start     = 1'b1;
    @(posedge clock);
    #1;
    mif.start = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("midop_busy_before_reset", {63'd0, mif.busy}, 64'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midop_reset_busy", {63'd0, mif.busy}, 64'd0);
    check("midop_reset_done", {63'd0, mif.done}, 64'd0);
    check("midop_reset_hilo", {mif.hi, mif.lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("midop_no_late_result", {mif.hi, mif.lo}, 64'd0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 0, lat, bc);
    check("post_reset_result", {mif.hi, mif.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    check("post_reset_latency", 64'(lat), 64'(LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
